// File: rtl/scpad_wxbar.sv
// scpad_wxbar: write crossbar permuting lane-ordered requests into bank-column order through a stallable pipeline
module scpad_wxbar #(
  parameter int IDX       = 0,
  parameter int NUM_COLS  = 32,
  parameter int ELEM_BITS = 16,
  parameter int SLOT_BITS = 8,
  parameter int SRC_BITS  = 4,
  parameter int LATENCY   = 2
) (
  input  logic                             clk,
  input  logic                             n_rst,
  input  logic                             stall,
  input  logic                             req_valid,
  input  logic                             req_write,
  input  logic [SRC_BITS-1:0]              req_src,
  input  logic [NUM_COLS-1:0]              req_valid_mask,
  input  logic [NUM_COLS*$clog2(NUM_COLS)-1:0] req_shift,
  input  logic [NUM_COLS*SLOT_BITS-1:0]    req_slot,
  input  logic [NUM_COLS*ELEM_BITS-1:0]    req_wdata,
  output logic                             bank_valid,
  output logic [SRC_BITS-1:0]              bank_src,
  output logic [NUM_COLS-1:0]              bank_we,
  output logic [NUM_COLS*SLOT_BITS-1:0]    bank_slot,
  output logic [NUM_COLS*ELEM_BITS-1:0]    bank_wdata,
  output logic                             bank_conflict
);
  localparam int SHW = $clog2(NUM_COLS);
  localparam int W   = 2 + SRC_BITS + NUM_COLS * (1 + SLOT_BITS + ELEM_BITS);

  if (LATENCY < 1 || NUM_COLS < 2 || IDX < 0) begin : g_param_check
    $error("scpad_wxbar: invalid parameters");
  end

  logic [NUM_COLS-1:0]           we;
  logic [NUM_COLS*SLOT_BITS-1:0] slot;
  logic [NUM_COLS*ELEM_BITS-1:0] wdata;
  logic                          conflict;
  logic [SHW-1:0]                dst;
  logic [W-1:0]                  pipe [LATENCY];

  // Walk lanes high-to-low so the lowest-index lane is the last writer and wins its column.
  always_comb begin
    we       = '0;
    slot     = '0;
    wdata    = '0;
    conflict = 1'b0;
    dst      = '0;
    for (int i = NUM_COLS - 1; i >= 0; i--) begin
      dst = SHW'(i) + req_shift[i*SHW +: SHW];
      if (req_valid_mask[i]) begin
        conflict = conflict | we[dst];
        we[dst] = 1'b1;
        slot[dst*SLOT_BITS +: SLOT_BITS] = req_slot[i*SLOT_BITS +: SLOT_BITS];
        wdata[dst*ELEM_BITS +: ELEM_BITS] = req_wdata[i*ELEM_BITS +: ELEM_BITS];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      for (int s = 0; s < LATENCY; s++) pipe[s] <= '0;
    end else if (!stall) begin
      pipe[0] <= (req_valid & req_write) ? {1'b1, conflict, req_src, we, slot, wdata} : '0;
      for (int s = 1; s < LATENCY; s++) pipe[s] <= pipe[s-1];
    end
  end

  assign {bank_valid, bank_conflict, bank_src, bank_we, bank_slot, bank_wdata} = pipe[LATENCY-1];
endmodule

// File: doc/scpad_wxbar.md
Name: scpad_wxbar

Overview:
- Write-direction crossbar for one scratchpad bank group (index IDX); the transmit-side counterpart of the read crossbar.
- Takes a lane-ordered write request from the head/stomach path and permutes each lane's element, slot address and enable into bank-column order.
- Carries the request's src tag alongside the permuted data through a fixed LATENCY-deep, stall-controlled pipeline.
- Feeds the bank write ports directly.

Parameters:
- IDX, 0, scratchpad instance index. Informational; carried for hookup symmetry.
- NUM_COLS, 32, lanes per request and bank columns. Power of two, ≥2.
- ELEM_BITS, 16, bits per element.
- SLOT_BITS, 8, per-column row (slot) address width.
- SRC_BITS, 4, requester tag width.
- LATENCY, 2, advancing cycles from request accept to bank output. Must be ≥1.

Ports:
- clk  in  1  clock
- n_rst  in  1  synchronous active-low reset
- stall  in  1  1 = freeze the whole pipeline; inputs are not sampled
- req_valid  in  1  request present
- req_write  in  1  1 = write request; reads are bubbled
- req_src  in  SRC_BITS  requester tag
- req_valid_mask  in  NUM_COLS  per-lane enable
- req_shift  in  NUM_COLS*log2(NUM_COLS)  per-lane rotate amount
- req_slot  in  NUM_COLS*SLOT_BITS  per-lane row address
- req_wdata  in  NUM_COLS*ELEM_BITS  per-lane element
- bank_valid  out  1  beat valid
- bank_src  out  SRC_BITS  tag of the beat
- bank_we  out  NUM_COLS  per-column write enable
- bank_slot  out  NUM_COLS*SLOT_BITS  per-column row address
- bank_wdata  out  NUM_COLS*ELEM_BITS  per-column element
- bank_conflict  out  1  two or more enabled lanes targeted one column

Behaviour:
- Reset: clk rising edge with n_rst=0 clears every pipeline stage. All outputs are 0 on the following cycle. Reset overrides stall. In-flight beats are discarded and are not replayed.
- Accept rule: a beat is captured on any edge where stall=0. Captured valid = req_valid & req_write.
  - If the captured valid is 0, the stage loads all-zero fields (a bubble).
- Destination: lane i maps to column (i + req_shift[i]) mod NUM_COLS, truncated to log2(NUM_COLS) bits. Wrap-around is natural modulo.
- Participation: only lanes with req_valid_mask[i]=1 participate.
- Column c, computed combinationally at stage 0:
  - we[c] = OR of participating lanes mapping to c.
  - wdata[c] and slot[c] come from the lowest-index participating lane mapping to c.
  - A column with no source gets we=0, wdata=0, slot=0.
- Conflict flag: asserted when any column has ≥2 participating sources. The flag travels with the beat. The winning (lowest-index) lane is still written.
- Pipeline: stage 0 registers the permuted beat. Stages 1..LATENCY-1 are pure delay. Outputs are driven directly from the last stage.
- Latency: a beat accepted at edge k appears on outputs after the LATENCY-th non-stalled edge, counting edge k as the first.
- stall=1: every stage and output holds its value, and inputs are ignored. The requester must hold or replay its request.
- No backpressure exists other than stall, and no internal buffering exists beyond the pipeline. Back-to-back beats stream one per non-stalled cycle.
- Src passthrough: bank_src equals the req_src of the same beat. For bubbles, bank_src = 0.

Test Plan (NUM_COLS=32, ELEM_BITS=16, LATENCY=2):
1. Reset: hold n_rst=0 for 2 cycles with req_valid=1 and write=1 driven -> all outputs 0. The first post-reset beat appears exactly 2 edges after its accept.
2. Identity: shift=0, mask=0xFFFFFFFF, wdata[i]=i, slot[i]=0x10, src=3 -> 2 edges later: bank_valid=1, bank_we=0xFFFFFFFF, bank_wdata[c]=c, bank_slot[c]=0x10, bank_src=3, conflict=0.
3. Wrap: shift[i]=1 for all lanes, wdata[i]=i -> bank_wdata[0]=0x001F, bank_wdata[c]=c-1 for c≥1, bank_we all ones.
4. Read gating and mask: req_valid=1, write=0 -> bank_valid=0 and all fields 0. Then write=1 with mask=0x0000000F and shift=0 -> bank_we=0x0000000F, columns 4..31 zero.
5. Stall: beat A (wdata all 0xA5A5) accepted at edge 0, stall=1 for edges 1-3 while inputs change to B, then stall=0 -> outputs hold their pre-stall values during the stall. A appears after edge 4, and B is never captured unless re-presented.
6. Conflict: mask enables lanes 3 and 5 only; shift[3]=4, shift[5]=2; wdata 0xAAAA and 0xBBBB; slots 0x01 and 0x02 -> bank_we=0x00000080, bank_wdata[7]=0xAAAA, bank_slot[7]=0x01, bank_conflict=1.
